// File: rtl/hamming_pkg.sv
// Shared types, FSM encoding and parity bit positions for the 11-bit
// Hamming (15,11) + overall-parity encoder.
package hamming_pkg;

  typedef logic [11:1] msg_t;
  typedef logic [15:0] codeword_t;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/hamming_enc11.sv
// Combinational SECDED encoder: 11 data bits to a 16-bit codeword with
// Hamming parity at power-of-two positions and overall even parity at bit 0.
module hamming_enc11
  import hamming_pkg::*;
(
  input  msg_t      msg,
  output codeword_t cw
);

  logic p8, p4, p2, p1, p0;

  always_comb begin
    p8 = ^msg[11:5];
    p4 = ^{msg[11:8], msg[4:2]};
    p2 = ^{msg[11], msg[10], msg[7], msg[6], msg[4], msg[3], msg[1]};
    p1 = ^{msg[11], msg[9], msg[7], msg[5], msg[4], msg[2], msg[1]};
    p0 = ^{msg, p8, p4, p2, p1};

    cw         = '0;
    cw[15:9]   = msg[11:5];
    cw[P8_POS] = p8;
    cw[7:5]    = msg[4:2];
    cw[P4_POS] = p4;
    cw[3]      = msg[1];
    cw[P2_POS] = p2;
    cw[P1_POS] = p1;
    cw[P0_POS] = p0;
  end

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-to-memory Hamming encoder: reads NUM_MSGS two-byte messages from
// SRC_BASE, writes two-byte codewords to DST_BASE, five cycles per message.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata
);

  localparam int IDX_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSGS - 1);

  // Assertion is immediate; release is delayed two edges so the FSM never
  // sees a deassertion that races the clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Stage p0: message bytes captured one cycle after each read request.
  logic [7:0] lo_byte_p0;
  logic [2:0] hi_bits_p0;

  always_ff @(posedge clk) begin
    if (state == RD_HI)  lo_byte_p0 <= mem_rdata;
    if (state == CAP_HI) hi_bits_p0 <= mem_rdata[2:0];
  end

  msg_t      msg;
  codeword_t cw;

  assign msg = {hi_bits_p0, lo_byte_p0};

  hamming_enc11 u_enc (
    .msg (msg),
    .cw  (cw)
  );

  logic [ADDR_W-1:0] pair_off, src_addr, dst_addr;

  assign pair_off = ADDR_W'(idx) << 1;
  assign src_addr = ADDR_W'(SRC_BASE) + pair_off;
  assign dst_addr = ADDR_W'(DST_BASE) + pair_off;

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RD_LO;
          idx_nx   = '0;
        end
      end
      RD_LO: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr;
        state_nx  = RD_HI;
      end
      RD_HI: begin
        mem_rd_en = 1'b1;
        mem_addr  = src_addr + ADDR_W'(1);
        state_nx  = CAP_HI;
      end
      CAP_HI: begin
        state_nx = WR_LO;
      end
      WR_LO: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = cw[7:0];
        state_nx  = WR_HI;
      end
      WR_HI: begin
        mem_wr_en = 1'b1;
        mem_addr  = dst_addr + ADDR_W'(1);
        mem_wdata = cw[15:8];
        if (idx == LAST_IDX) begin
          state_nx = DONE;
        end else begin
          state_nx = RD_LO;
          idx_nx   = idx + IDX_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed bench for hamming_enc_engine: table of messages with expected
// codewords, write-sequence timing, restart, mid-run start and reset abort.
module tb_hamming_enc_engine;

  localparam int DST = 30;
  localparam int NM  = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  always #5 clk = ~clk;

  hamming_enc_engine #(
    .NUM_MSGS (NM),
    .SRC_BASE (0),
    .DST_BASE (DST),
    .ADDR_W   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    int          t;
  } wr_t;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  logic [7:0] src_mem [256];
  wr_t        wlog[$];
  int         cyc = 0;
  int         overlap_cnt = 0;
  int         stray_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  vec_t       vecs [NM];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= src_mem[mem_addr];
    if (mem_wr_en) wlog.push_back('{mem_addr, mem_wdata, cyc});
  end

  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) overlap_cnt <= overlap_cnt + 1;
    if ((!mem_rd_en && !mem_wr_en && mem_addr != 8'h00) ||
        (!mem_wr_en && mem_wdata != 8'h00))
      stray_cnt <= stray_cnt + 1;
  end

  // Reference encoder in classic position form: data fills non-power-of-two
  // positions 3..15, parity k covers positions with bit k set.
  function automatic logic [15:0] model_cw(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (pos[b]) p = p ^ c[pos];
      c[1 << b] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Syndrome decoder: {status, data}; status 2'b01 means one bit corrected.
  function automatic logic [12:0] decode(input logic [15:0] c);
    logic [3:0]  s;
    logic [1:0]  st;
    logic [10:0] d;
    int          k;
    s = 4'h0;
    for (int pos = 1; pos < 16; pos++)
      if (c[pos]) s = s ^ pos[3:0];
    if (^c)           st = 2'b01;
    else if (s != 0)  st = 2'b10;
    else              st = 2'b00;
    if (s != 0) c[s] = ~c[s];
    k = 0;
    d = '0;
    for (int pos = 1; pos < 16; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        d[k] = c[pos];
        k++;
      end
    end
    return {st, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_wait(input int pa, input int pb, output int k);
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i == pa) || (i == pb);
      @(posedge clk);
      #1;
      if (done) begin
        k = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic accept_start(output int t_acc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic check_log(input int base, input int t_acc, input string tag);
    logic [15:0] e;
    logic [31:0] got, want;
    int          m, rel;
    check({tag, "_nwrites"}, wlog.size() - base, 2 * NM);
    for (int j = 0; j < 2 * NM; j++) begin
      m = j / 2;
      e = vecs[m].exp;
      want = {8'h00, 8'(DST + j), (j % 2) ? e[15:8] : e[7:0], 8'(5 * m + 4 + j % 2)};
      if (base + j < wlog.size()) begin
        rel = wlog[base + j].t - t_acc + 1;
        got = {8'h00, wlog[base + j].addr, wlog[base + j].data, rel[7:0]};
      end else begin
        got = 32'hFFFF_FFFF;
      end
      check($sformatf("%s_wr%0d", tag, j), got, want);
    end
  endtask

  initial begin
    int          k, t_acc, base, n44, n45;
    logic [15:0] cw;
    logic [10:0] d;
    logic        ok;
    logic        seen;

    vecs[0]  = '{8'h00, 8'h00, 16'h0000};
    vecs[1]  = '{8'hFF, 8'h07, 16'hFFFF};
    vecs[2]  = '{8'h01, 8'h00, 16'h000F};
    vecs[3]  = '{8'h00, 8'h04, 16'h8117};
    vecs[4]  = '{8'h00, 8'hF8, 16'h0000};
    vecs[5]  = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[6]  = '{8'h80, 8'h00, 16'h1111};
    vecs[7]  = '{8'h55, 8'h05, 16'h0000};
    vecs[8]  = '{8'hAA, 8'h02, 16'h0000};
    vecs[9]  = '{8'h23, 8'h01, 16'h0000};
    vecs[10] = '{8'hA5, 8'h07, 16'h0000};
    vecs[11] = '{8'hF0, 8'h00, 16'h0000};
    vecs[12] = '{8'h0C, 8'h03, 16'h0000};
    vecs[13] = '{8'hB1, 8'h06, 16'h0000};
    vecs[14] = '{8'h9E, 8'h01, 16'h0000};
    for (int m = 7; m < NM; m++)
      vecs[m].exp = model_cw({vecs[m].hi[2:0], vecs[m].lo});

    for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
    for (int m = 0; m < NM; m++) begin
      src_mem[2 * m]     = vecs[m].lo;
      src_mem[2 * m + 1] = vecs[m].hi;
    end

    // Reset state
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",  done,      0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr",  mem_addr,  0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_done", done, 0);

    // Full run: codewords, write order and timing
    base = wlog.size();
    accept_start(t_acc);
    check("acc_done_low", done, 0);
    run_wait(0, 0, k);
    check("done_latency", k, 75);
    check_log(base, t_acc, "runA");

    for (int m = 0; m < NM; m++) begin
      if (base + 2 * m + 1 < wlog.size())
        cw = {wlog[base + 2 * m + 1].data, wlog[base + 2 * m].data};
      else
        cw = 16'h0000;
      d = {vecs[m].hi[2:0], vecs[m].lo};
      check($sformatf("model%0d", m), cw, model_cw(d));
      ok = 1'b1;
      for (int b = 0; b < 16; b++) begin
        cw[b] = ~cw[b];
        if (decode(cw) !== {2'b01, d}) ok = 1'b0;
        cw[b] = ~cw[b];
      end
      check($sformatf("decode%0d", m), ok, 1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("done_held", done, 1);

    // Restart while done is high, with extra start pulses mid-run
    base = wlog.size();
    accept_start(t_acc);
    check("restart_done_drop", done, 0);
    run_wait(10, 41, k);
    check("midstart_latency", k, 75);
    check_log(base, t_acc, "runB");

    // Reset asserted during WR_LO of message 7
    base = wlog.size();
    accept_start(t_acc);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (mem_wr_en && mem_addr == 8'(DST + 14)) begin
        seen = 1'b1;
        break;
      end
    end
    check("wr_lo7_seen", seen, 1);
    reset = 1'b0;
    #1;
    check("abort_wr_en", mem_wr_en, 0);
    check("abort_addr",  mem_addr,  0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_done",  done,      0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done || mem_wr_en || mem_rd_en) k++;
    end
    check("abort_idle_quiet", k, 0);
    n44 = 0;
    n45 = 0;
    for (int j = base; j < wlog.size(); j++) begin
      if (wlog[j].addr == 8'(DST + 14)) n44++;
      if (wlog[j].addr == 8'(DST + 15)) n45++;
    end
    check("abort_nwrites", wlog.size() - base, 14);
    check("abort_no_wr44", n44, 0);
    check("abort_no_wr45", n45, 0);

    base = wlog.size();
    accept_start(t_acc);
    run_wait(0, 0, k);
    check("post_abort_latency", k, 75);
    check_log(base, t_acc, "runC");

    check("no_rd_wr_overlap", overlap_cnt, 0);
    check("idle_outputs_zero", stray_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_enc_engine.md
HAMMING_ENC_ENGINE -- requirements
Module: hamming_enc_engine

Interface
REQ-001 SHALL have parameter NUM_MSGS, default 15: number of 11-bit messages encoded per run.
REQ-002 SHALL have parameter SRC_BASE, default 0: byte address of the first input message.
REQ-003 SHALL have parameter DST_BASE, default 30: byte address of the first output codeword.
REQ-004 SHALL have parameter ADDR_W, default 8: memory address width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request to begin one encoding run.
REQ-008 SHALL have port done, output, 1: run complete (level).
REQ-009 SHALL have port mem_addr, output, ADDR_W: byte address for read or write.
REQ-010 SHALL have port mem_rd_en, output, 1: read request; data returns on mem_rdata one cycle later.
REQ-011 SHALL have port mem_rdata, input, 8: read data.
REQ-012 SHALL have port mem_wr_en, output, 1: write strobe; the write commits at the rising edge where it is high.
REQ-013 SHALL have port mem_wdata, output, 8: write data.

Function
REQ-014 Input message i SHALL be stored little-endian: low byte d[8:1] at SRC_BASE+2i, high byte bits [2:0] = d[11:9] at SRC_BASE+2i+1.
REQ-015 The block SHALL ignore bits [7:3] of the high input byte.
REQ-016 Codeword i SHALL be {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0}, written low byte to DST_BASE+2i and high byte to DST_BASE+2i+1.
REQ-017 Parity bits SHALL be computed as follows:
- p8 = XOR of d[11:5].
- p4 = XOR of d[11:8] and d[4:2].
- p2 = XOR of d11, d10, d7, d6, d4, d3 and d1.
- p1 = XOR of d11, d9, d7, d5, d4, d2 and d1.
- p0 = XOR of all 11 data bits and p8, p4, p2, p1, giving even overall parity.
REQ-018 The FSM SHALL have states IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI and DONE.
REQ-019 From IDLE or DONE, start=1 SHALL clear done, clear the message index to 0 and go to RD_LO.
REQ-020 In RD_LO the block SHALL drive mem_rd_en=1 with mem_addr=SRC_BASE+2i.
REQ-021 In RD_HI the block SHALL drive mem_rd_en=1 with mem_addr=SRC_BASE+2i+1 and capture mem_rdata as the low byte.
REQ-022 In CAP_HI the block SHALL capture mem_rdata[2:0] as the high data bits, with no memory access.
REQ-023 In WR_LO the block SHALL drive mem_wr_en=1 with the codeword's low byte at DST_BASE+2i.
REQ-024 In WR_HI the block SHALL drive mem_wr_en=1 with the codeword's high byte at DST_BASE+2i+1.
REQ-025 From WR_HI, the block SHALL go to DONE if i==NUM_MSGS-1; otherwise it SHALL go to RD_LO with i+1.
REQ-026 Each message SHALL take exactly 5 cycles, so done SHALL rise 5*NUM_MSGS cycles after the start-accept edge (75 cycles at defaults).
REQ-027 done SHALL stay high in DONE until the next accepted start.
REQ-028 start SHALL be ignored in every state other than IDLE and DONE.
REQ-029 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-030 mem_addr and mem_wdata SHALL be 0 whenever the corresponding enable is low.
REQ-031 Address arithmetic SHALL be ADDR_W bits wide and wrap modulo 2^ADDR_W with no error flag.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, index 0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0 and mem_wdata=0.
REQ-033 Reset asserted mid-run SHALL abort the run with no further writes; on release the block SHALL wait in IDLE for start.
REQ-034 Reset deassertion SHALL be synchronised to clk before it reaches the FSM.

Structure
REQ-035 Package hamming_pkg SHALL hold typedefs msg_t [11:1] and codeword_t [15:0] plus the parity bit-position constants.
REQ-036 The parity computation SHALL be one combinational sub-module, hamming_enc11 (msg_t in, codeword_t out), instantiated once.

Verification
REQ-037 Message 11'h000 -> codeword 16'h0000; done high 75 cycles after start at defaults.
REQ-038 Message 11'h7FF -> 16'hFFFF; 11'h001 -> 16'h000F; 11'h400 -> 16'h8117.
REQ-039 High input byte 8'hF8 with low byte 8'h00 -> codeword 16'h0000, confirming upper bits are ignored.
REQ-040 15 random messages -> each codeword matches the REQ-017 model; flipping any single codeword bit in the program-2 decoder yields the corrected data with MSBs 2'b01.
REQ-041 start pulsed again mid-run -> ignored, with write sequence and timing unchanged.
REQ-042 Second start while done is high -> done drops the next cycle and the run repeats.
REQ-043 reset pulsed low during WR_LO of message 7 -> no write to address 45; done stays 0 until a new start.
